hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 14 +
 rtl/mem_wait_fsm.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and types for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_MAX_INFLIGHT = 3;
    localparam int DEF_MEM_TIMEOUT  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mem_fsm_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// rtl/mem_wait_fsm.sv - memory handshake wait tracker with timeout error pulse
module mem_wait_fsm
    import hazard_scoreboard_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ready,
    output logic stall,
    output logic err
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

    mem_fsm_state_t state;
    logic [WW-1:0]  wait_cnt;

    // A ready arriving on the threshold cycle wins over the timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req && !ready) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (ready) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == LAST) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall = ((state == ST_IDLE) && req && !ready) || (state == ST_WAIT);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write counters and issue/memory stall logic
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                issue_valid_i,
    input  logic                issue_we_i,
    input  logic [RW-1:0]       issue_rd_i,
    input  logic [RW-1:0]       rs1_i,
    input  logic [RW-1:0]       rs2_i,
    input  logic                rs1_used_i,
    input  logic                rs2_used_i,
    output logic                issue_stall_o,
    input  logic                wb_valid_i,
    input  logic                wb_we_i,
    input  logic [RW-1:0]       wb_rd_i,
    input  logic                cancel_valid_i,
    input  logic [RW-1:0]       cancel_rd_i,
    input  logic                dmem_req_i,
    input  logic                dmem_ready_i,
    output logic                mem_stall_o,
    output logic                mem_err_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                underflow_err_o
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int EW = CW + 2;
    localparam logic [EW-1:0] MAX_E = EW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

    logic [CW-1:0]       cnt      [NUM_REGS];
    logic [CW-1:0]       cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] uf_hit;
    logic [NUM_REGS-1:0] busy;
    logic [EW-1:0]       up;
    logic [EW-1:0]       down;
    logic                issue_accept;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk   (clk_i),
        .reset (reset_i),
        .req   (dmem_req_i),
        .ready (dmem_ready_i),
        .stall (mem_stall_o),
        .err   (mem_err_o)
    );

    // Stall looks only at registered counts; a same-cycle writeback does not release it.
    assign issue_stall_o = (rs1_used_i && busy[rs1_i])
                        || (rs2_used_i && busy[rs2_i])
                        || (issue_we_i && (cnt[issue_rd_i] == MAX_C))
                        || mem_stall_o;

    assign issue_accept = issue_valid_i && !issue_stall_o;
    assign busy_o       = busy;

    always_comb begin
        cnt_next = cnt;
        uf_hit   = '0;
        busy     = '0;
        up       = '0;
        down     = '0;
        // Register 0 is never tracked, so the loop starts at 1.
        for (int r = 1; r < NUM_REGS; r++) begin
            up   = {2'b00, cnt[r]}
                 + EW'(issue_accept && issue_we_i && (issue_rd_i == RW'(r)));
            down = EW'(wb_valid_i && wb_we_i && (wb_rd_i == RW'(r)))
                 + EW'(cancel_valid_i && (cancel_rd_i == RW'(r)));
            if (down > up) begin
                cnt_next[r] = '0;
                uf_hit[r]   = 1'b1;
            end else if ((up - down) > MAX_E) begin
                cnt_next[r] = MAX_C;
            end else begin
                cnt_next[r] = CW'(up - down);
            end
            busy[r] = (cnt[r] != '0);
        end
        cnt_next[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            underflow_err_o <= 1'b0;
        end else begin
            cnt             <= cnt_next;
            underflow_err_o <= underflow_err_o | (|uf_hit);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a reference model
module tb_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int MAXI = 3;
    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        issue_valid_i, issue_we_i;
    logic [4:0]  issue_rd_i, rs1_i, rs2_i;
    logic        rs1_used_i, rs2_used_i;
    logic        wb_valid_i, wb_we_i;
    logic [4:0]  wb_rd_i;
    logic        cancel_valid_i;
    logic [4:0]  cancel_rd_i;
    logic        dmem_req_i, dmem_ready_i;
    logic        issue_stall_o, mem_stall_o, mem_err_o, underflow_err_o;
    logic [31:0] busy_o;

    int  total = 0;
    int  bad   = 0;

    int  cnt_m [NREG];
    bit  uf_m;
    int  waited;
    bit  err_now;

    logic        obs_is, obs_ms, obs_err, obs_uf;
    logic [31:0] obs_busy;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS(NREG), .MAX_INFLIGHT(MAXI), .MEM_TIMEOUT(TOUT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_rd_i(issue_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
        .issue_stall_o(issue_stall_o),
        .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
        .cancel_valid_i(cancel_valid_i), .cancel_rd_i(cancel_rd_i),
        .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .mem_stall_o(mem_stall_o), .mem_err_o(mem_err_o),
        .busy_o(busy_o), .underflow_err_o(underflow_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        reset_i = 1'b0;
        issue_valid_i = 1'b0; issue_we_i = 1'b0; issue_rd_i = '0;
        rs1_i = '0; rs2_i = '0; rs1_used_i = 1'b0; rs2_used_i = 1'b0;
        wb_valid_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0;
        cancel_valid_i = 1'b0; cancel_rd_i = '0;
        dmem_req_i = 1'b0; dmem_ready_i = 1'b1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
        uf_m = 1'b0;
        waited = -1;
        err_now = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        logic [31:0] e_busy;
        bit e_ms, e_is, acc;
        int net;
        @(negedge clk);
        e_busy = '0;
        for (int r = 1; r < NREG; r++) e_busy[r] = (cnt_m[r] > 0);
        e_ms = (waited >= 0) || (!err_now && dmem_req_i && !dmem_ready_i);
        e_is = (rs1_used_i && e_busy[rs1_i]) || (rs2_used_i && e_busy[rs2_i])
            || (issue_we_i && cnt_m[issue_rd_i] == MAXI) || e_ms;
        obs_is = issue_stall_o; obs_ms = mem_stall_o; obs_err = mem_err_o;
        obs_uf = underflow_err_o; obs_busy = busy_o;
        check("busy", busy_o, e_busy);
        check("issue_stall", {31'b0, issue_stall_o}, {31'b0, e_is});
        check("mem_stall", {31'b0, mem_stall_o}, {31'b0, e_ms});
        check("mem_err", {31'b0, mem_err_o}, {31'b0, err_now});
        check("underflow", {31'b0, underflow_err_o}, {31'b0, uf_m});
        @(posedge clk);
        if (reset_i) begin
            model_clear();
        end else begin
            acc = issue_valid_i && !e_is;
            for (int r = 1; r < NREG; r++) begin
                net = cnt_m[r];
                if (acc && issue_we_i && issue_rd_i == r) net++;
                if (wb_valid_i && wb_we_i && wb_rd_i == r) net--;
                if (cancel_valid_i && cancel_rd_i == r) net--;
                if (net < 0) begin net = 0; uf_m = 1'b1; end
                if (net > MAXI) net = MAXI;
                cnt_m[r] = net;
            end
            if (err_now) begin
                err_now = 1'b0;
            end else if (waited < 0) begin
                if (dmem_req_i && !dmem_ready_i) waited = 0;
            end else if (dmem_ready_i) begin
                waited = -1;
            end else if (waited == TOUT - 1) begin
                waited = -1;
                err_now = 1'b1;
            end else begin
                waited++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        idle_inputs();
    endtask

    initial begin
        int n;
        bit seen;
        idle_inputs();
        model_clear();
        do_reset();
        step();
        check("rst_busy", obs_busy, 32'h0);
        check("rst_err", {31'b0, obs_err}, 32'h0);
        check("rst_uf", {31'b0, obs_uf}, 32'h0);

        // back-to-back RAW on x5
        issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd5;
        step();
        issue_we_i = 1'b0; issue_rd_i = 5'd0; rs1_i = 5'd5; rs1_used_i = 1'b1;
        step(); check("raw_stall0", {31'b0, obs_is}, 32'h1);
        step(); check("raw_stall1", {31'b0, obs_is}, 32'h1);
        wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd5;
        step(); check("raw_no_bypass", {31'b0, obs_is}, 32'h1);
        wb_valid_i = 1'b0;
        step(); check("raw_release", {31'b0, obs_is}, 32'h0);
        idle_inputs();

        // saturation on x7
        issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd7;
        for (int i = 0; i < 3; i++) begin
            step(); check("sat_fill", {31'b0, obs_is}, 32'h0);
        end
        step(); check("sat_stall", {31'b0, obs_is}, 32'h1);
        wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd7;
        step(); check("sat_stall_wb_edge", {31'b0, obs_is}, 32'h1);
        wb_valid_i = 1'b0;
        step(); check("sat_accept", {31'b0, obs_is}, 32'h0);
        step(); check("sat_back_at_max", {31'b0, obs_is}, 32'h1);
        idle_inputs();
        wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd7;
        repeat (3) step();
        idle_inputs();
        step(); check("sat_drained", {31'b0, obs_busy[7]}, 32'h0);

        // simultaneous events on x9
        issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd9;
        step();
        wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd9;
        step();
        wb_valid_i = 1'b0;
        step();
        idle_inputs();
        wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd9;
        cancel_valid_i = 1'b1; cancel_rd_i = 5'd9;
        step(); check("sim_busy9_before", {31'b0, obs_busy[9]}, 32'h1);
        idle_inputs();
        step();
        check("sim_busy9_after", {31'b0, obs_busy[9]}, 32'h0);
        check("sim_no_uf", {31'b0, obs_uf}, 32'h0);

        // x0 never tracked; decrement at zero is a sticky error
        issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd0;
        step();
        idle_inputs();
        step(); check("x0_busy", obs_busy, 32'h0);
        wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd4;
        step();
        idle_inputs();
        step(); check("uf_set", {31'b0, obs_uf}, 32'h1);
        repeat (3) step();
        check("uf_sticky", {31'b0, obs_uf}, 32'h1);
        check("uf_busy4", {31'b0, obs_busy[4]}, 32'h0);

        // memory timeout
        do_reset();
        dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
        step(); check("to_req_stall", {31'b0, obs_ms}, 32'h1);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (obs_err) seen = 1'b1;
            else if (obs_ms) n++;
        end
        check("to_err_seen", {31'b0, seen}, 32'h1);
        check("to_stall_len", n, TOUT);
        check("to_err_release", {31'b0, obs_ms}, 32'h0);
        idle_inputs();
        step(); check("to_err_one_cycle", {31'b0, obs_err}, 32'h0);

        // ready on the last wait cycle beats the timeout
        dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
        step();
        repeat (TOUT - 1) step();
        check("rdy_last_still_stall", {31'b0, obs_ms}, 32'h1);
        dmem_ready_i = 1'b1;
        step();
        idle_inputs();
        seen = 1'b0;
        repeat (4) begin
            step();
            if (obs_err) seen = 1'b1;
        end
        check("rdy_last_no_err", {31'b0, seen}, 32'h0);

        // reset in the middle of a wait with x3 pending twice
        issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd3;
        repeat (2) step();
        issue_valid_i = 1'b0; issue_we_i = 1'b0;
        dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
        repeat (4) step();
        check("mid_busy3", {31'b0, obs_busy[3]}, 32'h1);
        reset_i = 1'b1;
        step();
        idle_inputs();
        step();
        check("mid_busy", obs_busy, 32'h0);
        check("mid_err", {31'b0, obs_err}, 32'h0);
        check("mid_stall", {31'b0, obs_ms}, 32'h0);
        seen = 1'b0;
        repeat (20) begin
            step();
            if (obs_err) seen = 1'b1;
        end
        check("mid_no_late_err", {31'b0, seen}, 32'h0);

        // randomized traffic on a small register window to force hazards
        for (int i = 0; i < 3000; i++) begin
            reset_i        = (i % 1000 == 999);
            issue_valid_i  = ($urandom_range(0, 99) < 60);
            issue_we_i     = ($urandom_range(0, 99) < 80);
            issue_rd_i     = 5'($urandom_range(0, 7));
            rs1_i          = 5'($urandom_range(0, 7));
            rs2_i          = 5'($urandom_range(0, 7));
            rs1_used_i     = ($urandom_range(0, 99) < 50);
            rs2_used_i     = ($urandom_range(0, 99) < 30);
            wb_valid_i     = ($urandom_range(0, 99) < 45);
            wb_we_i        = ($urandom_range(0, 99) < 85);
            wb_rd_i        = 5'($urandom_range(0, 7));
            cancel_valid_i = ($urandom_range(0, 99) < 10);
            cancel_rd_i    = 5'($urandom_range(0, 7));
            dmem_req_i     = ($urandom_range(0, 99) < 30);
            dmem_ready_i   = (i % 600 >= 570) ? 1'b0 : ($urandom_range(0, 99) < 65);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
